// File: rtl/osc_cfg_bank_if.sv
// Byte-wide host bus used to program and read back the oscillator config bank.
interface osc_cfg_bank_if #(
  parameter int ADDR_W = 5
) ();
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              rvalid;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, rvalid);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/osc_cfg_bank.sv
// Double-buffered per-channel oscillator config bank; readback 1 cycle after rd_en.
// Active sets reload on frame_tick after COMMIT or at once on IMMEDIATE; the bus never stalls.
module osc_cfg_bank #(
  parameter int  CHANNELS = 2,
  parameter int  COEFF_W  = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int NB       = COEFF_W / 8,
  localparam int BY_W     = (NB > 1) ? $clog2(NB) : 1,
  localparam int ADDR_W   = CH_W + 3 + BY_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  osc_cfg_bank_if.slave               bus,
  input  logic [CHANNELS-1:0]         frame_tick,
  output logic [CHANNELS*COEFF_W-1:0] init_re,
  output logic [CHANNELS*COEFF_W-1:0] init_im,
  output logic [CHANNELS*COEFF_W-1:0] re_coeff,
  output logic [CHANNELS*COEFF_W-1:0] im_coeff,
  output logic [CHANNELS*COEFF_W-1:0] power,
  output logic [CHANNELS-1:0]         cfg_update
);

  // Field order inside a set: init_re, init_im, re_coeff, im_coeff, power (regs 2..6).
  logic [4:0][COEFF_W-1:0] shadow [CHANNELS];
  logic [4:0][COEFF_W-1:0] active [CHANNELS];
  logic [CHANNELS-1:0]     pending;
  logic [CHANNELS-1:0]     lock;
  logic                    err;
  logic [7:0]              rdata_q;
  logic                    rvalid_q;

  logic [ADDR_W-1:0] addr;
  logic [CH_W-1:0]   a_ch;
  logic [2:0]        a_reg;
  logic [BY_W-1:0]   a_by;
  logic              ch_ok, by_ok, lock_sel;
  logic              wr_status, wr_ctrl, wr_shadow, wr_bad;
  logic [CHANNELS-1:0] copy;
  logic [7:0]        rd_byte;

  function automatic logic [COEFF_W-1:0] def_val(input int f);
    logic [7:0] v;
    case (f)
      0:       v = 8'h20;
      1:       v = 8'h00;
      2:       v = 8'h7d;
      3:       v = 8'h1b;
      default: v = 8'h10;
    endcase
    return COEFF_W'(v) << (COEFF_W - 8);
  endfunction

  assign addr  = bus.addr;
  assign a_by  = addr[BY_W-1:0];
  assign a_reg = addr[BY_W+2:BY_W];
  assign a_ch  = addr[ADDR_W-1:BY_W+3];
  assign ch_ok = int'(a_ch) < CHANNELS;
  assign by_ok = int'(a_by) < NB;

  always_comb begin
    lock_sel  = 1'b0;
    wr_status = 1'b0;
    wr_ctrl   = 1'b0;
    wr_shadow = 1'b0;
    wr_bad    = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      if (int'(a_ch) == c) lock_sel = lock[c];
    if (bus.wr_en) begin
      if (!ch_ok || a_reg == 3'd7 || !by_ok)     wr_bad    = 1'b1;
      else if (a_reg <= 3'd1 && a_by != '0)      wr_bad    = 1'b1;
      else if (a_reg == 3'd0)                    wr_status = 1'b1;
      else if (lock_sel)                         wr_bad    = 1'b1;  // STATUS W1C is exempt from lock
      else if (a_reg == 3'd1)                    wr_ctrl   = 1'b1;
      else                                       wr_shadow = 1'b1;
    end
  end

  always_comb begin
    copy = '0;
    for (int c = 0; c < CHANNELS; c++)
      copy[c] = (wr_ctrl && int'(a_ch) == c && bus.wdata[1]) || (pending[c] && frame_tick[c]);
  end

  always_comb begin
    rd_byte = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(a_ch) == c) begin
        if (a_reg == 3'd0 && a_by == '0) rd_byte = {5'b0, err, lock[c], pending[c]};
        for (int f = 0; f < 5; f++)
          for (int b = 0; b < NB; b++)
            if (int'(a_reg) == f + 2 && int'(a_by) == b) rd_byte = shadow[c][f][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int f = 0; f < 5; f++) begin
          shadow[c][f] <= def_val(f);
          active[c][f] <= def_val(f);
        end
      pending    <= '0;
      lock       <= '0;
      err        <= 1'b0;
      cfg_update <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      cfg_update <= copy;
      rvalid_q   <= bus.rd_en;
      if (bus.rd_en) rdata_q <= rd_byte;
      if (wr_bad)                          err <= 1'b1;
      else if (wr_status && bus.wdata[2])  err <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        // A tick that lands on an already-pending channel commits; a repeat COMMIT adds nothing.
        if (copy[c]) begin
          active[c]  <= shadow[c];
          pending[c] <= 1'b0;
        end else if (wr_ctrl && int'(a_ch) == c && bus.wdata[0]) begin
          pending[c] <= 1'b1;
        end
        if (wr_ctrl && int'(a_ch) == c && bus.wdata[7]) lock[c] <= 1'b1;
        for (int f = 0; f < 5; f++)
          for (int b = 0; b < NB; b++)
            if (wr_shadow && int'(a_ch) == c && int'(a_reg) == f + 2 && int'(a_by) == b)
              shadow[c][f][8*b +: 8] <= bus.wdata;
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    assign init_re [c*COEFF_W +: COEFF_W] = active[c][0];
    assign init_im [c*COEFF_W +: COEFF_W] = active[c][1];
    assign re_coeff[c*COEFF_W +: COEFF_W] = active[c][2];
    assign im_coeff[c*COEFF_W +: COEFF_W] = active[c][3];
    assign power   [c*COEFF_W +: COEFF_W] = active[c][4];
  end

endmodule
